// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the two-port BRAM arbiter.
package bram_arb_pkg;

    localparam int unsigned NumReq        = 2;
    localparam int unsigned DefAddrW      = 8;
    localparam int unsigned DefDataW      = 8;
    localparam int unsigned DefTimeoutCyc = 15;
    // Wide enough for the largest supported timeout (255).
    localparam int unsigned CntW          = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

endpackage

// File: rtl/bram_arbiter_if.sv
// Requester and BRAM-side signal bundle for bram_arbiter.
// The master side is the environment (requesters plus BRAM); the slave side is the arbiter.
interface bram_arbiter_if import bram_arb_pkg::*; #(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
);
    logic [NumReq-1:0]        req;
    logic [NumReq-1:0]        req_we;
    logic [NumReq*ADDR_W-1:0] req_addr;
    logic [NumReq*DATA_W-1:0] req_wdata;
    logic [NumReq-1:0]        gnt;
    logic [NumReq-1:0]        ack;
    logic                     err;
    logic [DATA_W-1:0]        rdata;
    logic                     busy;
    logic [ADDR_W-1:0]        bram_address;
    logic [DATA_W-1:0]        bram_data_in;
    logic                     bram_wr_en;
    logic                     bram_rd_en;
    logic [DATA_W-1:0]        bram_data_out;
    logic                     bram_op_done;

    modport master (
        output req, req_we, req_addr, req_wdata, bram_data_out, bram_op_done,
        input  gnt, ack, err, rdata, busy, bram_address, bram_data_in, bram_wr_en, bram_rd_en
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata, bram_data_out, bram_op_done,
        output gnt, ack, err, rdata, busy, bram_address, bram_data_in, bram_wr_en, bram_rd_en
    );
endinterface

// File: rtl/bram_arbiter_rr_arbiter.sv
// Combinational two-input round-robin selector: ptr names the requester with priority.
module rr_arbiter (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

    // Priority requester wins if asking, otherwise the other one.
    always_comb begin
        win = 2'b00;
        if (ptr) begin
            if (req[1])      win = 2'b10;
            else if (req[0]) win = 2'b01;
        end else begin
            if (req[0])      win = 2'b01;
            else if (req[1]) win = 2'b10;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester round-robin sequencer in front of a single-port BRAM.
// Each grant issues exactly one enable pulse, waits for op_done (or a timeout)
// and returns a one-cycle ack. All outputs are registered.
module bram_arbiter import bram_arb_pkg::*; #(
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input  logic           clk,
    input  logic           rst_n,
    bram_arbiter_if.slave  bus
);

    state_e              state_q, state_d;
    logic [NumReq-1:0]   gnt_q, gnt_d;
    logic [NumReq-1:0]   ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic                ptr_q, ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [1:0]          win;
    logic                win_we;

    rr_arbiter u_rr (
        .req (bus.req),
        .ptr (ptr_q),
        .win (win)
    );

    assign win_we = win[1] ? bus.req_we[1] : bus.req_we[0];

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|win) begin
                    gnt_d   = win;
                    we_d    = win_we;
                    addr_d  = win[1] ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
                    wdata_d = win[1] ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
                    // Enables are registered, so they rise together with ISSUE.
                    wr_en_d = win_we;
                    rd_en_d = ~win_we;
                    ptr_d   = ~win[1];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (bus.bram_op_done) begin
                    if (!we_q) rdata_d = bus.bram_data_out;
                    ack_d   = gnt_q;
                    state_d = StDone;
                end else if (cnt_q == CntW'(TIMEOUT_CYC)) begin
                    err_d   = 1'b1;
                    ack_d   = gnt_q;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.ack          = ack_q;
    assign bus.err          = err_q;
    assign bus.rdata        = rdata_q;
    assign bus.busy         = busy_q;
    assign bus.bram_address = addr_q;
    assign bus.bram_data_in = wdata_q;
    assign bus.bram_wr_en   = wr_en_q;
    assign bus.bram_rd_en   = rd_en_q;

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-port round-robin arbiter and sequencer for the single-port 256×8 BRAM_Module in the 65 MHz domain. Lets two independent requesters (e.g. UART command path and pattern checker) share one BRAM instance. Each accepted request becomes exactly one rd_en or wr_en pulse; the block waits for the BRAM's op_done and returns a one-cycle ack with read data or error. Sits directly between the requester logic and BRAM_Module; owns every BRAM control input.

## Interface
- NUM_REQ, 2, number of requesters (fixed at 2 in this revision)
- ADDR_W, 8, BRAM address width
- DATA_W, 8, BRAM data width
- TIMEOUT_CYC, 15, WAIT cycles without op_done before error completion (1..255)
- clk  in  1  65 MHz clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  request per requester; hold high until ack
- req_we  in  NUM_REQ  1 = write, 0 = read; bit i belongs to requester i
- req_addr  in  NUM_REQ*ADDR_W  address; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  write data, same packing
- gnt  out  NUM_REQ  one-hot grant, high from ISSUE through DONE
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  1  valid with ack; 1 = timeout
- rdata  out  DATA_W  read data, valid with ack on successful read
- busy  out  1  high whenever state ≠ IDLE
- bram_address  out  ADDR_W  to BRAM address
- bram_data_in  out  DATA_W  to BRAM data_in
- bram_wr_en  out  1  to BRAM wr_en
- bram_rd_en  out  1  to BRAM rd_en
- bram_data_out  in  DATA_W  from BRAM data_out
- bram_op_done  in  1  from BRAM op_done

## Operation
- States: IDLE, ISSUE, WAIT, DONE; all outputs registered.
- IDLE: if any req high, pick winner via round-robin, latch its we/addr/wdata, set gnt, go ISSUE. No req → stay.
- Round-robin: priority pointer starts at requester 0; after a grant, pointer moves to the requester after the winner. Only one requester → it wins regardless of pointer.
- ISSUE (exactly one cycle): bram_wr_en = latched we, bram_rd_en = ~we, address/data driven from latch; never both enables. Go WAIT; clear timeout counter.
- WAIT: enables low. op_done high → capture bram_data_out into rdata (reads only), err = 0, go DONE. Counter reaches TIMEOUT_CYC → err = 1, rdata unchanged, go DONE.
- DONE (one cycle): ack[winner] = 1; go IDLE; gnt clears on entry to IDLE.
- Writes leave rdata unchanged; ack still pulses.
- req changes while granted are ignored; attributes latched at grant only.
- Requester dropping req before ack: transaction still completes and acks.
- Reset values: gnt 0, ack 0, err 0, rdata 0, busy 0, all bram_* outputs 0, pointer 0, state IDLE.
- Reset mid-transaction: immediate return to IDLE, no ack; the in-flight BRAM write may or may not have landed.

## Timing
- Req sampled high in IDLE at cycle T → enable high during T+1 → op_done during T+2 → ack during T+3 → IDLE at T+4.
- Nominal latency: 3 cycles request-to-ack; peak throughput one transaction per 4 cycles.
- Requester drives req low the cycle after ack, or keeps it high with new attributes for a back-to-back request; sampled again at T+4.
- Both requesting continuously: grants strictly alternate.
- Timeout: ack at T+2+TIMEOUT_CYC+1 with err = 1.

## Structure
- Package bram_arb_pkg: state enum, ADDR_W/DATA_W defaults, TIMEOUT_CYC default, counter width.
- Sub-module rr_arbiter: combinational two-input round-robin selector (req, pointer → one-hot winner); FSM, latches, pointer register stay in bram_arbiter.

## Test plan
- Reset, requester 0 reads addr 10 (BRAM initial contents) → one rd_en pulse, ack[0] 3 cycles after sample, rdata 0xA5, err 0.
- Requester 1 writes 0x3C to addr 5, then reads addr 5 → wr_en then rd_en pulses, second ack rdata 0x3C.
- Both request from the same cycle, holding req continuously → grants alternate 0,1,0,1; never both enables high.
- Requester 1 reads addr 200 while requester 0 idle, then both request → requester 0 wins (pointer advanced past 1).
- BRAM model suppresses op_done → ack with err 1 after TIMEOUT_CYC (15) WAIT cycles, rdata unchanged.
- Assert rst_n low during WAIT → all outputs 0 immediately, no ack; next request completes normally.
